serial_rx: RTL and testbench

Deserializer for the LCD serial link (sd/cs/sck/rs): the receive-side counterpart of the packet serializer. It oversamples the four link pins in the system clock domain, rebuilds MSB-first words and the rs bit into packets, and presents them on a valid/ready port. It is used as a loopback/monitor in the lcd_basic design and bench, and as the front end for any peripheral that speaks the same link.

---
 rtl/serial_pkg.sv | 14 +
 rtl/sync_ff.sv | 25 ++
 rtl/serial_rx.sv | 135 +++++++++++++
 tb/tb_serial_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the LCD serial link (serializer and deserializer).
// Holds the receiver state encoding and the default word/packet geometry.
package serial_pkg;

  localparam int SERIAL_WORD_WIDTH   = 8;
  localparam int SERIAL_PACKET_WIDTH = 9;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for pins driven outside the clk domain.
// All link pins share the same depth so their relative alignment is preserved.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// Receive side of the LCD serial link: oversamples sd/cs/sck/rs, rebuilds
// MSB-first words tagged with rs, and offers them through a one-entry slot.
module serial_rx
  import serial_pkg::*;
#(
  parameter int WORD_WIDTH   = SERIAL_WORD_WIDTH,
  parameter int PACKET_WIDTH = SERIAL_PACKET_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sd,
  input  logic                    cs,
  input  logic                    sck,
  input  logic                    rs,
  output logic                    valid,
  input  logic                    ready,
  output logic [PACKET_WIDTH-1:0] data,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  logic sd_s;
  logic cs_s;
  logic sck_s;
  logic rs_s;
  logic sck_prev_r;
  logic sck_rise_s;
  logic slot_free_s;
  logic word_done_s;

  state_t                  state_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [WORD_WIDTH-1:0]   shift_r;
  logic [WORD_WIDTH-1:0]   next_word_s;
  logic                    valid_r;
  logic [PACKET_WIDTH-1:0] data_r;
  logic                    overrun_r;
  logic                    frame_err_r;

  function automatic logic [PACKET_WIDTH-1:0] make_packet(
    input logic                  rs_bit,
    input logic [WORD_WIDTH-1:0] word
  );
    logic [PACKET_WIDTH-1:0] pkt;
    pkt                   = {PACKET_WIDTH{1'b0}};
    pkt[WORD_WIDTH-1:0]   = word;
    pkt[PACKET_WIDTH-1]   = rs_bit;
    return pkt;
  endfunction

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd  (.clk(clk), .rst(rst), .d(sd),  .q(sd_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk(clk), .rst(rst), .d(cs),  .q(cs_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst(rst), .d(sck), .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rs  (.clk(clk), .rst(rst), .d(rs),  .q(rs_s));

  // Edge detect, next shifted word and slot availability.
  always_comb begin
    sck_rise_s     = sck_s & ~sck_prev_r;
    next_word_s    = shift_r << 1;
    next_word_s[0] = sd_s;
    slot_free_s    = ~valid_r | ready;
    word_done_s    = (bit_cnt_r == CNT_W'(WORD_WIDTH - 1));
  end

  // Receive FSM, shift register and output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_r     <= {WORD_WIDTH{1'b0}};
      sck_prev_r  <= 1'b0;
      valid_r     <= 1'b0;
      data_r      <= {PACKET_WIDTH{1'b0}};
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      sck_prev_r  <= sck_s;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        HUNT: begin
          bit_cnt_r <= {CNT_W{1'b0}};
          if (cs_s) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          bit_cnt_r <= {CNT_W{1'b0}};
          if (!cs_s) begin
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          // A cs rise takes priority over any sck edge in the same cycle.
          if (cs_s) begin
            if (bit_cnt_r != {CNT_W{1'b0}}) begin
              frame_err_r <= 1'b1;
            end
            bit_cnt_r <= {CNT_W{1'b0}};
            state_r   <= IDLE;
          end else if (sck_rise_s) begin
            shift_r <= next_word_s;
            if (word_done_s) begin
              bit_cnt_r <= {CNT_W{1'b0}};
              if (slot_free_s) begin
                valid_r <= 1'b1;
                data_r  <= make_packet(rs_s, next_word_s);
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r   <= HUNT;
          bit_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign valid     = valid_r;
  assign data      = data_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: drives the link bit by bit, models the
// expected packets and error pulses, and checks every DUT transfer.
module tb_serial_rx;

  localparam int WW = 8;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          sd;
  logic          cs;
  logic          sck;
  logic          rs;
  logic          ready;
  logic          valid;
  logic [PW-1:0] data;
  logic          overrun;
  logic          frame_err;

  serial_rx #(.WORD_WIDTH(WW), .PACKET_WIDTH(PW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sd(sd), .cs(cs), .sck(sck), .rs(rs),
    .valid(valid), .ready(ready), .data(data),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            fe_cnt   = 0;
  int            ov_cnt   = 0;
  int            exp_fe   = 0;
  int            exp_ov   = 0;
  logic [PW-1:0] sb_q[$];
  logic          fe_prev  = 1'b0;
  logic          ov_prev  = 1'b0;
  bit            model_on = 1'b0;
  bit            drop_mode = 1'b0;
  int            m_cnt    = 0;
  logic [WW-1:0] m_word   = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pkt_of(input logic r, input logic [WW-1:0] w);
    logic [PW-1:0] p;
    p         = '0;
    p[WW-1:0] = w;
    p[PW-1]   = r;
    return p;
  endfunction

  // Output monitor: every valid cycle must present the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) begin
        fe_cnt++;
        check_val("fe_width", fe_prev, 0);
      end
      if (overrun) begin
        ov_cnt++;
        check_val("ov_width", ov_prev, 0);
      end
      if (valid) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_valid", valid, 0);
        end else begin
          check_val("data", data, sb_q[0]);
          if (ready) void'(sb_q.pop_front());
        end
      end
    end
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic r, input int lo, input int hi,
                          input bit coincide, input bit lat_chk);
    sd = b;
    rs = r;
    wait_clk(lo);
    sck = 1'b1;
    if (coincide) cs = 1'b1;
    if (!coincide && model_on) begin
      m_word = {m_word[WW-2:0], b};
      m_cnt++;
      if (m_cnt == WW) begin
        m_cnt = 0;
        if (drop_mode) exp_ov++;
        else sb_q.push_back(pkt_of(r, m_word));
      end
    end
    if (lat_chk) begin
      @(posedge clk);
      @(negedge clk) check_val("lat_n", valid, 0);
      @(posedge clk);
      @(negedge clk) check_val("lat_n1", valid, 0);
      @(posedge clk);
      @(negedge clk) check_val("lat_n2", valid, 1);
      wait_clk(1);
    end else begin
      wait_clk(hi);
    end
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input logic r, input bit lat_chk);
    for (int i = WW - 1; i >= 0; i--) send_bit(w[i], r, 2, 2, 1'b0, lat_chk && (i == 0));
  endtask

  task automatic frame_start();
    cs       = 1'b0;
    model_on = 1'b1;
    m_cnt    = 0;
    wait_clk(3);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    if (model_on && m_cnt != 0) exp_fe++;
    m_cnt = 0;
    wait_clk(6);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
    wait_clk(4);
    check_val({tag, "_drain"}, sb_q.size(), 0);
    check_val({tag, "_fe_cnt"}, fe_cnt, exp_fe);
    check_val({tag, "_ov_cnt"}, ov_cnt, exp_ov);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; sd = 1'b0; rs = 1'b0; ready = 1'b1;
    wait_clk(3);
    @(negedge clk);
    check_val("rst_valid", valid, 0);
    check_val("rst_data", data, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_frame_err", frame_err, 0);
    wait_clk(1);
    rst = 1'b0;
    wait_clk(6);

    // Single word 1,0,1,0,0,1,0,1 with rs=1, including output latency.
    frame_start();
    send_word(8'hA5, 1'b1, 1'b1);
    frame_end();
    settle("single");

    // Burst of two words in one cs-low window.
    frame_start();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'hFF, 1'b1, 1'b0);
    frame_end();
    settle("burst");

    // Backpressure: first word held, the next two dropped.
    ready = 1'b0;
    frame_start();
    send_word(8'h12, 1'b0, 1'b0);
    drop_mode = 1'b1;
    send_word(8'h34, 1'b1, 1'b0);
    send_word(8'h56, 1'b0, 1'b0);
    frame_end();
    drop_mode = 1'b0;
    wait_clk(10);
    check_val("bp_held", sb_q.size(), 1);
    check_val("bp_valid", valid, 1);
    ready = 1'b1;
    settle("bp");

    // Partial word then a full word.
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
    frame_end();
    frame_start();
    send_word(8'h81, 1'b0, 1'b0);
    frame_end();
    settle("partial");

    // Reset mid-word with cs held low.
    frame_start();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 2, 2, 1'b0, 1'b0);
    rst      = 1'b1;
    model_on = 1'b0;
    m_cnt    = 0;
    wait_clk(2);
    @(negedge clk);
    check_val("mid_rst_valid", valid, 0);
    check_val("mid_rst_frame_err", frame_err, 0);
    wait_clk(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
    frame_end();
    frame_start();
    send_word(8'h55, 1'b0, 1'b0);
    frame_end();
    settle("reset");

    // Random frames with random sck phases and coincident sck/cs edges.
    for (int f = 0; f < 40; f++) begin
      int nb;
      bit co;
      nb = $urandom_range(1, 20);
      co = ($urandom_range(0, 3) == 0);
      frame_start();
      for (int b = 0; b < nb; b++) begin
        send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(2, 4), $urandom_range(2, 4), co && (b == nb - 1), 1'b0);
      end
      frame_end();
    end
    settle("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
